// File: rtl/parity_frame_gen_if.sv
// Serial bit-stream bus for the parity framer: input stream, mode controls and status.
interface parity_frame_gen_if #(
   parameter int unsigned FRAME_LEN = 8
);
   localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

   logic             odd;
   logic             check;
   logic             in_valid;
   logic             in;
   logic             in_ready;
   logic             out_valid;
   logic             out;
   logic             out_last;
   logic             parity;
   logic [CNT_W-1:0] bit_cnt;
   logic             frame_done;
   logic             parity_err;

   // Stream source / status observer side.
   modport master (
      output odd, check, in_valid, in,
      input  in_ready, out_valid, out, out_last, parity, bit_cnt, frame_done, parity_err
   );

   // Framer side.
   modport slave (
      input  odd, check, in_valid, in,
      output in_ready, out_valid, out, out_last, parity, bit_cnt, frame_done, parity_err
   );
endinterface

// File: rtl/parity_frame_gen.sv
// Serial parity framer: groups FRAME_LEN data bits per frame and appends (generate)
// or consumes and verifies (check) an even/odd parity bit.
module parity_frame_gen #(
   parameter int unsigned FRAME_LEN = 8
) (
   input logic               clk,
   input logic               rst_n,
   parity_frame_gen_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

   typedef enum logic {
      S_DATA = 1'b0,
      S_PAR  = 1'b1
   } state_t;

   state_t           state_q,      state_n;
   logic [CNT_W-1:0] bit_cnt_q,    bit_cnt_n;
   logic             parity_q,     parity_n;
   logic             odd_lat_q,    odd_lat_n;
   logic             chk_lat_q,    chk_lat_n;
   logic             out_q,        out_n;
   logic             out_valid_q,  out_valid_n;
   logic             out_last_q,   out_last_n;
   logic             frame_done_q, frame_done_n;
   logic             parity_err_q, parity_err_n;

   logic             in_ready_c;
   logic             accept_c;

   // Ready depends on registered state only; the parity slot accepts input only in check mode.
   assign in_ready_c = (state_q == S_DATA) | ((state_q == S_PAR) & chk_lat_q);
   assign accept_c   = bus.in_valid & in_ready_c;

   // Next-state and next-output logic.
   always_comb begin
      state_n      = state_q;
      bit_cnt_n    = bit_cnt_q;
      parity_n     = parity_q;
      odd_lat_n    = odd_lat_q;
      chk_lat_n    = chk_lat_q;
      out_n        = out_q;
      out_valid_n  = 1'b0;
      out_last_n   = 1'b0;
      frame_done_n = 1'b0;
      parity_err_n = 1'b0;

      case (state_q)
         S_DATA: begin
            if (accept_c) begin
               // Mode and sense are frozen at the first bit of a frame.
               if (bit_cnt_q == '0) begin
                  odd_lat_n = bus.odd;
                  chk_lat_n = bus.check;
               end
               bit_cnt_n   = bit_cnt_q + CNT_W'(1);
               parity_n    = parity_q ^ bus.in;
               out_n       = bus.in;
               out_valid_n = 1'b1;
               if (bit_cnt_n == CNT_W'(FRAME_LEN)) begin
                  state_n = S_PAR;
               end
            end
         end
         S_PAR: begin
            // Generate mode spends exactly one cycle here; check mode waits for the received bit.
            if (!chk_lat_q || accept_c) begin
               out_n        = chk_lat_q ? bus.in : (parity_q ^ odd_lat_q);
               out_valid_n  = 1'b1;
               out_last_n   = 1'b1;
               frame_done_n = 1'b1;
               parity_err_n = chk_lat_q & (parity_q ^ bus.in ^ odd_lat_q);
               bit_cnt_n    = '0;
               parity_n     = 1'b0;
               state_n      = S_DATA;
            end
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_DATA;
         bit_cnt_q    <= '0;
         parity_q     <= 1'b0;
         odd_lat_q    <= 1'b0;
         chk_lat_q    <= 1'b0;
         out_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_n;
         bit_cnt_q    <= bit_cnt_n;
         parity_q     <= parity_n;
         odd_lat_q    <= odd_lat_n;
         chk_lat_q    <= chk_lat_n;
         out_q        <= out_n;
         out_valid_q  <= out_valid_n;
         out_last_q   <= out_last_n;
         frame_done_q <= frame_done_n;
         parity_err_q <= parity_err_n;
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_q;
   assign bus.out        = out_q;
   assign bus.out_last   = out_last_q;
   assign bus.parity     = parity_q;
   assign bus.bit_cnt    = bit_cnt_q;
   assign bus.frame_done = frame_done_q;
   assign bus.parity_err = parity_err_q;
endmodule
